// File: rtl/imm_enc.sv
// -----------------------------------------------------------------------------
// imm_enc -- RISC-V immediate field encoder with 2-entry output buffer
//
// Purpose:
//   Inserts a signed immediate into the I/S/B-type field positions of a base
//   instruction word. This is the inverse of the immediate extend stage.
//   Immediates that would not survive a round trip through the extend stage
//   are flagged on RangeErr. Words that raise RangeErr are still encoded from
//   the low immediate bits and still emitted. The output side has an output
//   register plus a skid register. Because of this, InReady is a registered
//   signal with no combinational path from OutReady.
//
// Build option:
//   IMM_ENC_STATS_EN -- when defined, the EncCount and ErrCount registers are
//   built. When undefined, both outputs are tied to 0. Encoding, handshake and
//   RangeErr are identical in both builds.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (synchronous release expected)
//   InValid    in   input transaction valid
//   InReady    out  block can accept input this cycle (registered)
//   ImmSrc     in   00 I-type, 01 S-type, 10 B-type, 11 reserved
//   Imm        in   signed immediate (byte offset for B-type)
//   BaseInstr  in   opcode/rd/rs/funct fields; immediate positions ignored
//   OutValid   out  encoded word valid
//   OutReady   in   consumer accepts the word
//   InstrOut   out  encoded instruction
//   RangeErr   out  sideband of InstrOut: immediate not representable
//   EncCount   out  accepted transactions, wraps
//   ErrCount   out  accepted transactions with RangeErr, saturates at 255
// -----------------------------------------------------------------------------
module imm_enc #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [1:0]                   ImmSrc,
    input  logic [INSTRUCTION_WIDTH-1:0] Imm,
    input  logic [INSTRUCTION_WIDTH-1:0] BaseInstr,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [INSTRUCTION_WIDTH-1:0] InstrOut,
    output logic                         RangeErr,
    output logic [CNT_WIDTH-1:0]         EncCount,
    output logic [7:0]                   ErrCount
);

    localparam int W = INSTRUCTION_WIDTH;

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Range check.
    // A value fits in an N-bit signed field when every bit from N-1 upward
    // equals the sign bit. same_as_msb[gi] marks each bit that agrees with
    // Imm[W-1].
    // -------------------------------------------------------------------------
    logic [W-1:11] same_as_msb;

    generate
        for (genvar gi = 11; gi < W; gi++) begin : g_sign
            assign same_as_msb[gi] = ~(Imm[gi] ^ Imm[W-1]);
        end
    endgenerate

    logic fits_12; // Imm[31:11] all equal: fits 12-bit signed (I/S)
    logic fits_13; // Imm[31:12] all equal: fits 13-bit signed (B)

    assign fits_12 = &same_as_msb;
    assign fits_13 = &same_as_msb[W-1:12];

    // -------------------------------------------------------------------------
    // Field placement. This path is combinational from the inputs and is
    // sampled into the buffer on accept.
    // -------------------------------------------------------------------------
    logic [W-1:0] enc_word;
    logic         enc_err;

    always_comb begin
        enc_word = BaseInstr;
        enc_err  = 1'b0;
        case (ImmSrc)
            SRC_I: begin
                enc_word[31:20] = Imm[11:0];
                enc_err         = ~fits_12;
            end
            SRC_S: begin
                enc_word[31:25] = Imm[11:5];
                enc_word[11:7]  = Imm[4:0];
                enc_err         = ~fits_12;
            end
            SRC_B: begin
                enc_word[31]    = Imm[12];
                enc_word[30:25] = Imm[10:5];
                enc_word[11:8]  = Imm[4:1];
                enc_word[7]     = Imm[11];
                // Branch offsets must be halfword aligned: bit 0 has no field.
                enc_err         = ~fits_13 | Imm[0];
            end
            default: begin
                // The reserved selector passes the base word through and flags it.
                enc_word = BaseInstr;
                enc_err  = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Buffer control
    // -------------------------------------------------------------------------
    state_t state_reg, state_next;
    logic   in_ready_reg, in_ready_next;

    logic   accept;
    logic   pop;
    logic   load_out_new;  // new word goes to the output register
    logic   load_skid;     // new word is parked in the skid register
    logic   load_out_skid; // skid register moves to the output register

    assign OutValid = (state_reg != ST_EMPTY);
    assign InReady  = in_ready_reg;
    assign accept   = InValid & in_ready_reg;
    assign pop      = OutValid & OutReady;

    always_comb begin
        state_next    = state_reg;
        load_out_new  = 1'b0;
        load_skid     = 1'b0;
        load_out_skid = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next   = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // InReady is low here, so no accept can arrive.
                if (pop) begin
                    state_next    = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        // InReady is registered from the next state, so it never depends
        // combinationally on OutReady.
        in_ready_next = (state_next != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // -------------------------------------------------------------------------
    // Data registers
    // -------------------------------------------------------------------------
    logic [W-1:0] out_word_reg;
    logic         out_err_reg;
    logic [W-1:0] skid_word_reg;
    logic         skid_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_reg  <= '0;
            out_err_reg   <= 1'b0;
            skid_word_reg <= '0;
            skid_err_reg  <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_word_reg <= enc_word;
                out_err_reg  <= enc_err;
            end else if (load_out_skid) begin
                out_word_reg <= skid_word_reg;
                out_err_reg  <= skid_err_reg;
            end
            if (load_skid) begin
                skid_word_reg <= enc_word;
                skid_err_reg  <= enc_err;
            end
        end
    end

    assign InstrOut = out_word_reg;
    assign RangeErr = out_err_reg;

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
`ifdef IMM_ENC_STATS_EN
    logic [CNT_WIDTH-1:0] enc_cnt_reg;
    logic [7:0]           err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else if (accept) begin
            enc_cnt_reg <= enc_cnt_reg + 1'b1;
            if (enc_err && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign EncCount = enc_cnt_reg;
    assign ErrCount = err_cnt_reg;
`else
    assign EncCount = '0;
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// -----------------------------------------------------------------------------
// tb_imm_enc -- self-checking bench for imm_enc.
// The reference model computes field placement with masks and shifts, and the
// range check with signed bounds. The buffer is modelled as a queue of at most
// two words.
// -----------------------------------------------------------------------------
module tb_imm_enc;

`ifdef IMM_ENC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [1:0]  ImmSrc = 2'b00;
    logic [31:0] Imm = '0;
    logic [31:0] BaseInstr = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] InstrOut;
    logic        RangeErr;
    logic [15:0] EncCount;
    logic [7:0]  ErrCount;

    imm_enc #(.INSTRUCTION_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .ImmSrc    (ImmSrc),
        .Imm       (Imm),
        .BaseInstr (BaseInstr),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .InstrOut  (InstrOut),
        .RangeErr  (RangeErr),
        .EncCount  (EncCount),
        .ErrCount  (ErrCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [32:0] q[$];          // {err, word}, head = word on the output
    int unsigned enc_cnt = 0;
    int          err_cnt = 0;
    bit          last_acc;
    int          cycle = 0;
    logic [31:0] dut_emit[$];
    int          dut_emit_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_enc(input logic [1:0] src, input logic [31:0] imm,
                                            input logic [31:0] base);
        logic [31:0] w;
        logic        e;
        int          s;
        s = $signed(imm);
        case (src)
            2'd0: begin
                w = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                e = !(s >= -2048 && s <= 2047);
            end
            2'd1: begin
                w = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = !(s >= -2048 && s <= 2047);
            end
            2'd2: begin
                w = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                  | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 32'h1) << 7);
                e = !(s >= -4096 && s <= 4095 && (imm % 2) == 0);
            end
            default: begin
                w = base;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic check_state();
        check("in_ready", InReady, q.size() < 2);
        check("out_valid", OutValid, q.size() > 0);
        if (q.size() > 0) begin
            check("instr_out", InstrOut, q[0][31:0]);
            check("range_err", RangeErr, q[0][32]);
        end
        check("enc_count", EncCount, STATS ? (enc_cnt & 32'hFFFF) : 0);
        check("err_count", ErrCount, STATS ? err_cnt : 0);
    endtask

    // Called at a falling edge, with the inputs already driven for the next rising edge.
    task automatic tick();
        bit acc, pp;
        logic [32:0] r;
        acc = InValid && (q.size() < 2);
        pp  = (q.size() > 0) && OutReady;
        if (OutValid && OutReady) begin
            dut_emit.push_back(InstrOut);
            dut_emit_cyc.push_back(cycle);
        end
        if (pp) void'(q.pop_front());
        if (acc) begin
            r = ref_enc(ImmSrc, Imm, BaseInstr);
            q.push_back(r);
            enc_cnt = (enc_cnt + 1) & 32'hFFFF;
            if (r[32] && err_cnt < 255) err_cnt++;
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        check_state();
    endtask

    task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] exp_word, input logic exp_err, input string tag);
        ImmSrc = src; Imm = imm; BaseInstr = base; InValid = 1'b1; OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        check({tag, "_word"}, InstrOut, exp_word);
        check({tag, "_err"}, RangeErr, exp_err);
        tick();
    endtask

    logic [32:0] ea, eb, ec;

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_out_valid", OutValid, 0);
        check("rst_instr_out", InstrOut, 0);
        check("rst_range_err", RangeErr, 0);
        check("rst_enc_count", EncCount, 0);
        check("rst_err_count", ErrCount, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state();

        // ---------------- directed encodings ----------------
        send(2'b00, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0, "i_type");
        check("i_type_enc_count", EncCount, STATS ? 1 : 0);
        send(2'b01, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0, "s_type");
        send(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, "b_type");

        send(2'b00, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 1'b1, "i_range");
        check("err_count_1", ErrCount, STATS ? 1 : 0);
        send(2'b10, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1, "b_range");
        check("err_count_2", ErrCount, STATS ? 2 : 0);
        send(2'b11, 32'h0000_0010, 32'h1234_5677, 32'h1234_5677, 1'b1, "reserved");
        check("err_count_3", ErrCount, STATS ? 3 : 0);

        // ---------------- backpressure ----------------
        ea = ref_enc(2'b00, 32'd5, 32'h0000_0013);
        eb = ref_enc(2'b01, 32'hFFFF_FFFC, 32'h0000_2023);
        ec = ref_enc(2'b10, 32'd16, 32'h0000_0063);
        OutReady = 1'b0;
        ImmSrc = 2'b00; Imm = 32'd5; BaseInstr = 32'h0000_0013; InValid = 1'b1;
        tick();
        check("bp_a_accepted", last_acc, 1);
        ImmSrc = 2'b01; Imm = 32'hFFFF_FFFC; BaseInstr = 32'h0000_2023;
        tick();
        check("bp_inready_low", InReady, 0);
        ImmSrc = 2'b10; Imm = 32'd16; BaseInstr = 32'h0000_0063;
        tick();
        check("bp_c_held", last_acc, 0);
        check("bp_stall_word", InstrOut, ea[31:0]);
        tick();
        check("bp_stall_word2", InstrOut, ea[31:0]);
        dut_emit.delete();
        dut_emit_cyc.delete();
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_acc) InValid = 1'b0;
        end
        InValid = 1'b0;
        check("bp_emit_count", dut_emit.size(), 3);
        if (dut_emit.size() == 3) begin
            check("bp_emit_a", dut_emit[0], ea[31:0]);
            check("bp_emit_b", dut_emit[1], eb[31:0]);
            check("bp_emit_c", dut_emit[2], ec[31:0]);
            check("bp_consec_ab", dut_emit_cyc[1] - dut_emit_cyc[0], 1);
            check("bp_consec_bc", dut_emit_cyc[2] - dut_emit_cyc[1], 1);
        end

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 800; i++) begin
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            ImmSrc   = 2'($urandom_range(0, 3));
            BaseInstr = $urandom;
            case ($urandom_range(0, 3))
                0: Imm = $urandom;
                1: Imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: Imm = 32'($signed($urandom_range(0, 4095)) - 2048) & 32'hFFFF_FFFE;
                default: Imm = {{20{1'b0}}, 12'($urandom)} ^ {20'hFFFFF * 32'($urandom_range(0, 1)), 12'h0};
            endcase
            tick();
        end

        // ---------------- error counter saturation ----------------
        OutReady = 1'b1;
        InValid  = 1'b1;
        ImmSrc   = 2'b11;
        for (int i = 0; i < 300; i++) begin
            BaseInstr = $urandom;
            tick();
        end
        InValid = 1'b0;
        tick();
        check("err_saturated", ErrCount, STATS ? 255 : 0);

        // ---------------- reset mid-operation ----------------
        OutReady = 1'b0;
        ImmSrc = 2'b00; Imm = 32'd7; BaseInstr = 32'h0000_0013; InValid = 1'b1;
        tick();
        Imm = 32'd9;
        tick();
        InValid = 1'b0;
        check("mid_two_inready", InReady, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", OutValid, 0);
        check("mid_rst_instr_out", InstrOut, 0);
        check("mid_rst_range_err", RangeErr, 0);
        check("mid_rst_enc_count", EncCount, 0);
        check("mid_rst_err_count", ErrCount, 0);
        q.delete();
        enc_cnt = 0;
        err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        OutReady = 1'b1;
        dut_emit.delete();
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_stale", dut_emit.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
